// File: rtl/jtag_debug_scan_master.sv
// Virtual-JTAG initiator: each command performs one IR update, one DR_WIDTH-bit capture/shift/update and run-test-idle.
// Optional macro JTAG_SCAN_RTI_HOLD_EN stretches RTI to RTI_TCKS tck periods.
module jtag_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2,
    parameter int RTI_TCKS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam int CNT_MAX = (DR_WIDTH > RTI_TCKS) ? DR_WIDTH : RTI_TCKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;

    state_t              state, next_state;
    logic [DIV_W-1:0]    div_cnt;
    logic                tck_q;
    logic                tdi_q;
    logic [CNT_W-1:0]    period_cnt;
    logic [DR_WIDTH-1:0] shift;
    logic [IR_WIDTH-1:0] ir_q;

    logic scanning, half_done, tck_rise, tck_fall, accept, rti_last;

    assign scanning  = (state != IDLE) && (state != RESP);
    assign half_done = scanning && (div_cnt == DIV_LAST);
    assign tck_rise  = half_done && !tck_q;
    assign tck_fall  = half_done && tck_q;
    assign accept    = cmd_valid && cmd_ready;

`ifdef JTAG_SCAN_RTI_HOLD_EN
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_TCKS - 1);
    assign rti_last = (period_cnt == RTI_LAST);
`else
    assign rti_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = UIR;
            UIR:     if (tck_fall) next_state = CDR;
            CDR:     if (tck_fall) next_state = SDR;
            SDR:     if (tck_fall && period_cnt == SDR_LAST) next_state = UDR;
            UDR:     if (tck_fall) next_state = RTI;
            RTI:     if (tck_fall && rti_last) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the shift register is reset too, so rsp_dr and tdi come up as clean zeros.
        if (reset) begin
            div_cnt    <= '0;
            tck_q      <= 1'b0;
            tdi_q      <= 1'b0;
            period_cnt <= '0;
            shift      <= '0;
            ir_q       <= '0;
        end else begin
            // tck runs only while scanning; each state starts in the low half of a fresh period
            if (!scanning) begin
                div_cnt <= '0;
                tck_q   <= 1'b0;
            end else if (half_done) begin
                div_cnt <= '0;
                tck_q   <= ~tck_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (next_state != state) period_cnt <= '0;
            else if (tck_fall)       period_cnt <= period_cnt + 1'b1;

            if (accept) begin
                shift <= cmd_dr;
                ir_q  <= cmd_ir;
            end else if (state == SDR && tck_rise) begin
                shift <= {vji_tdo, shift[DR_WIDTH-1:1]};
            end

            if (tck_fall) tdi_q <= (next_state == SDR) ? shift[0] : 1'b0;
        end
    end

    always_comb begin
        vji_uir   = 1'b0;
        vji_cdr   = 1'b0;
        vji_sdr   = 1'b0;
        vji_udr   = 1'b0;
        vji_rti   = 1'b0;
        rsp_valid = 1'b0;
        rsp_dr    = '0;
        case (state)
            UIR:     vji_uir = 1'b1;
            CDR:     vji_cdr = 1'b1;
            SDR:     vji_sdr = 1'b1;
            UDR:     vji_udr = 1'b1;
            RTI:     vji_rti = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_dr    = shift;
            end
            default: ;
        endcase
        cmd_ready = (state == IDLE) && !reset;
        busy      = scanning;
        vji_ir_in = (state == IDLE) ? '0 : ir_q;
        vji_tck   = tck_q;
        vji_tdi   = tdi_q;
    end

endmodule
